// File: rtl/iir_out_buffer.sv
// Output buffer for the IIR filter: captures each y sample into a small FWFT FIFO,
// streams it out over valid/ready, and counts samples lost while the FIFO is full.
module iir_out_buffer #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] drop_cnt,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, drop;

  assign full      = (level_q == FULL_LVL);
  assign empty     = (level_q == '0);
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // Clear takes priority over a coincident drop.
    if (clr_ovf) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {CW{1'b1}}) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_iir_out_buffer.sv
// Scoreboard bench for iir_out_buffer: a default instance and a CW=2 instance share
// the same stimulus; expected data is queued on push and compared as it is popped.
module tb_iir_out_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        clr_ovf;

  logic        out_valid,  out_valid2;
  logic [31:0] out_data,   out_data2;
  logic [2:0]  level,      level2;
  logic        full,       full2;
  logic        empty,      empty2;
  logic [15:0] drop_cnt;
  logic [1:0]  drop_cnt2;
  logic        overflow,   overflow2;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q [$];
  int          m_drop16;
  int          m_drop2;
  logic        m_ovf;

  always #5 clk = ~clk;

  iir_out_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .full(full), .empty(empty),
    .drop_cnt(drop_cnt), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  iir_out_buffer #(.CW(2)) dut_cw2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .level(level2), .full(full2), .empty(empty2),
    .drop_cnt(drop_cnt2), .overflow(overflow2), .clr_ovf(clr_ovf)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_status();
    int sz;
    sz = exp_q.size();
    check("out_valid", 32'(out_valid), 32'(sz != 0));
    check("level",     32'(level),     32'(sz));
    check("full",      32'(full),      32'(sz == 4));
    check("empty",     32'(empty),     32'(sz == 0));
    check("drop_cnt",  32'(drop_cnt),  32'(m_drop16));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("cw2_level", 32'(level2),    32'(sz));
    check("cw2_valid", 32'(out_valid2), 32'(sz != 0));
    check("cw2_full",  32'(full2),     32'(sz == 4));
    check("cw2_empty", 32'(empty2),    32'(sz == 0));
    check("cw2_drop",  32'(drop_cnt2), 32'(m_drop2));
    check("cw2_ovf",   32'(overflow2), 32'(m_ovf));
    if (sz != 0) begin
      check("out_data",     out_data,  exp_q[0]);
      check("cw2_out_data", out_data2, exp_q[0]);
    end
  endtask

  // One clock cycle: drive, check current outputs, predict, advance.
  task automatic step(input logic v, input logic [31:0] d, input logic rdy, input logic clr);
    logic pop_e, full_e;
    in_valid = v; in_data = d; out_ready = rdy; clr_ovf = clr;
    #1;
    check_status();
    full_e = (exp_q.size() == 4);
    pop_e  = (exp_q.size() != 0) && rdy;
    $display("cycle: in_valid=%0b in_data=%0d out_ready=%0b clr=%0b level=%0d out_data=%0d",
             v, d, rdy, clr, level, out_data);
    if (pop_e) void'(exp_q.pop_front());
    if (v && (!full_e || pop_e)) exp_q.push_back(d);
    if (clr) begin
      m_drop16 = 0; m_drop2 = 0; m_ovf = 1'b0;
    end else if (v && full_e && !pop_e) begin
      m_ovf = 1'b1;
      if (m_drop16 < 65535) m_drop16++;
      if (m_drop2 < 3) m_drop2++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic v);
    in_valid = v; in_data = 32'd99; out_ready = 1'b0; clr_ovf = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_drop16 = 0; m_drop2 = 0; m_ovf = 1'b0;
    $display("reset applied (in_valid=%0b)", v);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    m_drop16 = 0; m_drop2 = 0; m_ovf = 1'b0;
    @(posedge clk); #1;

    // Reset state
    do_reset(1'b0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_full",  32'(full), 32'd0);

    // Three pushes held, then drained in order
    for (int i = 1; i <= 3; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    check("fill3_level", 32'(level), 32'd3);
    check("fill3_head",  out_data, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
    check("drain3_empty", 32'(empty), 32'd1);

    // Overfill: 10..13 stored, 14 and 15 dropped
    for (int i = 10; i <= 15; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_drop", 32'(drop_cnt), 32'd2);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Push into full FIFO with a simultaneous pop
    step(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 20; i <= 23; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'd24, 1'b1, 1'b0);
    check("pp_level", 32'(level), 32'd4);
    check("pp_drop",  32'(drop_cnt), 32'd0);
    check("pp_head",  out_data, 32'd21);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Streaming 1..12 through, pointers wrap three times
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 32'(i), 1'b1, 1'b0);
      check("stream_level", 32'(level), 32'd1);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check("stream_drop", 32'(drop_cnt), 32'd0);

    // Five drops, then clear coinciding with a sixth drop
    for (int i = 30; i <= 33; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'(40 + i), 1'b0, 1'b0);
    check("five_drop",  32'(drop_cnt), 32'd5);
    check("cw2_sat",    32'(drop_cnt2), 32'd3);
    step(1'b1, 32'd50, 1'b0, 1'b1);
    check("clr_drop",   32'(drop_cnt), 32'd0);
    check("clr_ovf",    32'(overflow), 32'd0);
    check("clr_cw2",    32'(drop_cnt2), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Reset mid-operation with in_valid high
    for (int i = 60; i <= 62; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    do_reset(1'b1);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_drop",  32'(drop_cnt), 32'd0);
    step(1'b1, 32'd7, 1'b0, 1'b0);
    check("post_rst_data", out_data, 32'd7);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
